song_recorder: RTL and testbench

SONG_RECORDER -- requirements
Module: song_recorder

---
 rtl/song_recorder.sv | 173 +++++++++++++++++
 tb/tb_song_recorder.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/song_recorder.sv
// Song recorder: packs a stream of 16-bit note words into fixed-size blocks of
// song RAM, each preceded by a header word. A song ends with a terminator
// word, unless the region fills up first.
module song_recorder #(
  parameter int unsigned BLOCK_NOTES = 8,        // note slots per block, at most 15
  parameter logic [15:0] PAD_NOTE    = 16'h0000,
  parameter int unsigned MAX_BLOCKS  = 14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  song_sel,
  input  logic        start,
  input  logic [15:0] note_in,
  input  logic        note_valid,
  output logic        note_ready,
  input  logic        flush,
  input  logic        finish,
  output logic        wr_en,
  output logic [8:0]  wr_addr,
  output logic [15:0] wr_data,
  output logic        busy,
  output logic        done,
  output logic        full,
  output logic [3:0]  block_count
);

  typedef enum logic [2:0] {
    StIdle,
    StCollect,
    StPad,
    StHeader,
    StTerm,
    StDone
  } state_t;

  localparam logic [3:0]  LAST_SLOT  = 4'(BLOCK_NOTES - 1);
  localparam logic [3:0]  MAX_CNT    = 4'(MAX_BLOCKS);
  localparam logic [8:0]  BLK_STRIDE = 9'(BLOCK_NOTES + 1);
  localparam logic [15:0] TERM_WORD  = 16'hBF00;

  state_t      r_state;
  state_t      w_state_next;
  logic [8:0]  r_blk_base;
  logic [3:0]  r_slot;
  logic [3:0]  r_block_idx;
  logic [3:0]  r_block_count;
  logic [3:0]  r_real_notes;
  logic        r_finishing;
  logic        r_full;
  logic        r_busy;
  logic        r_done;
  logic        r_note_ready;
  logic        r_wr_en;
  logic [8:0]  r_wr_addr;
  logic [15:0] r_wr_data;

  logic        w_accept;
  logic [3:0]  w_slot_eff;   // slot count including a note accepted this cycle
  logic        w_block_fill;
  logic        w_close;
  logic        w_last_block;

  assign w_accept     = note_valid & r_note_ready;
  assign w_slot_eff   = r_slot + {3'd0, w_accept};
  assign w_block_fill = w_accept && (r_slot == LAST_SLOT);
  assign w_close      = (flush || finish) && (w_slot_eff != 4'd0);
  assign w_last_block = (r_block_count + 4'd1) == MAX_CNT;

  // Next-state decode; all outputs are registered from it in the block below.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle, StDone: if (start) w_state_next = StCollect;
      StCollect: begin
        // A note arriving with flush/finish lands first; a filled block skips PAD.
        if (w_block_fill)  w_state_next = StHeader;
        else if (w_close)  w_state_next = StPad;
        else if (finish)   w_state_next = StTerm;
      end
      StPad:    if (r_slot == LAST_SLOT) w_state_next = StHeader;
      StHeader: begin
        if (w_last_block)     w_state_next = StDone;
        else if (r_finishing) w_state_next = StTerm;
        else                  w_state_next = StCollect;
      end
      StTerm:   w_state_next = StDone;
      default:  w_state_next = StIdle;
    endcase
  end

  // State, block bookkeeping and registered write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= StIdle;
      r_blk_base    <= 9'd0;
      r_slot        <= 4'd0;
      r_block_idx   <= 4'd0;
      r_block_count <= 4'd0;
      r_real_notes  <= 4'd0;
      r_finishing   <= 1'b0;
      r_full        <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_note_ready  <= 1'b0;
      r_wr_en       <= 1'b0;
      r_wr_addr     <= 9'd0;
      r_wr_data     <= 16'd0;
    end else begin
      r_state      <= w_state_next;
      r_note_ready <= (w_state_next == StCollect);
      r_busy       <= (w_state_next != StIdle) && (w_state_next != StDone);
      r_done       <= (w_state_next == StDone);
      r_wr_en      <= 1'b0;
      case (r_state)
        StIdle, StDone: begin
          if (start) begin
            r_blk_base    <= {song_sel, 7'd0};
            r_slot        <= 4'd0;
            r_block_idx   <= 4'd0;
            r_block_count <= 4'd0;
            r_full        <= 1'b0;
            r_finishing   <= 1'b0;
          end
        end
        StCollect: begin
          if (w_accept) begin
            r_wr_en   <= 1'b1;
            r_wr_addr <= r_blk_base + 9'd1 + {5'd0, r_slot};
            r_wr_data <= note_in;
            r_slot    <= w_slot_eff;
          end
          if (w_block_fill || w_close) begin
            r_real_notes <= w_slot_eff;
            r_finishing  <= finish;
          end
        end
        StPad: begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= r_blk_base + 9'd1 + {5'd0, r_slot};
          r_wr_data <= PAD_NOTE;
          r_slot    <= r_slot + 4'd1;
        end
        StHeader: begin
          r_wr_en       <= 1'b1;
          r_wr_addr     <= r_blk_base;
          r_wr_data     <= {4'hB, 4'h0, r_block_idx, r_real_notes};
          r_block_count <= r_block_count + 4'd1;
          // Base always advances so TERM writes at the next block base.
          r_blk_base    <= r_blk_base + BLK_STRIDE;
          r_block_idx   <= r_block_idx + 4'd1;
          r_slot        <= 4'd0;
          if (w_last_block) r_full <= 1'b1;
        end
        StTerm: begin
          r_wr_en   <= 1'b1;
          r_wr_addr <= r_blk_base;
          r_wr_data <= TERM_WORD;
        end
        default: ;
      endcase
    end
  end

  assign note_ready  = r_note_ready;
  assign wr_en       = r_wr_en;
  assign wr_addr     = r_wr_addr;
  assign wr_data     = r_wr_data;
  assign busy        = r_busy;
  assign done        = r_done;
  assign full        = r_full;
  assign block_count = r_block_count;

endmodule

// File: tb/tb_song_recorder.sv
// Scoreboard bench for song_recorder: stimulus pushes expected RAM writes,
// a monitor pops and compares each observed write.
module tb_song_recorder;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  song_sel;
  logic        start;
  logic [15:0] note_in;
  logic        note_valid;
  logic        note_ready;
  logic        flush;
  logic        finish;
  logic        wr_en;
  logic [8:0]  wr_addr;
  logic [15:0] wr_data;
  logic        busy;
  logic        done;
  logic        full;
  logic [3:0]  block_count;

  int n_cmp = 0;
  int n_err = 0;
  logic [24:0] exp_q[$];

  song_recorder #(
    .BLOCK_NOTES(8),
    .PAD_NOTE   (16'h0000),
    .MAX_BLOCKS (14)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .song_sel   (song_sel),
    .start      (start),
    .note_in    (note_in),
    .note_valid (note_valid),
    .note_ready (note_ready),
    .flush      (flush),
    .finish     (finish),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .done       (done),
    .full       (full),
    .block_count(block_count)
  );

  always #5 clk = ~clk;

  // Monitor: every observed write must match the head of the expectation queue.
  always @(negedge clk) begin
    if (wr_en === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL write_unexpected: got addr %0d data %h, want no write", wr_addr, wr_data);
      end else begin
        logic [24:0] e;
        e = exp_q.pop_front();
        if ({wr_addr, wr_data} !== e) begin
          n_err++;
          $display("FAIL write: got addr %0d data %h, want addr %0d data %h",
                   wr_addr, wr_data, e[24:16], e[15:0]);
        end
      end
    end
  end

  task automatic expect_wr(input int a, input int d);
    logic [24:0] e;
    e = {a[8:0], d[15:0]};
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (note_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (note_ready !== 1'b1) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_ready: got note_ready %b, want 1 within 50 cycles", note_ready);
    end
  endtask

  task automatic wait_not_busy();
    int n = 0;
    while (busy !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) begin
      n_cmp++;
      n_err++;
      $display("FAIL wait_not_busy: got busy %b, want 0 within 50 cycles", busy);
    end
  endtask

  task automatic do_start(input logic [1:0] sel);
    song_sel = sel;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    song_sel = 2'd3;  // must be ignored from here on
  endtask

  task automatic send_note(input int d, input int a, input logic fl, input logic fi);
    wait_ready();
    note_in    = d[15:0];
    note_valid = 1'b1;
    flush      = fl;
    finish     = fi;
    expect_wr(a, d);
    @(negedge clk);
    note_valid = 1'b0;
    flush      = 1'b0;
    finish     = 1'b0;
  endtask

  task automatic close_pulse(input logic fl, input logic fi);
    wait_ready();
    flush  = fl;
    finish = fi;
    @(negedge clk);
    flush  = 1'b0;
    finish = 1'b0;
  endtask

  // First block of region 0: notes 1..8, header B008 at 0.
  task automatic full_block0(input int base_d);
    for (int s = 0; s < 8; s++) send_note(base_d + s, 1 + s, 1'b0, 1'b0);
    expect_wr(0, 16'hB008);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, want finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; song_sel = 2'd0; start = 1'b0; note_in = 16'd0;
    note_valid = 1'b0; flush = 1'b0; finish = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_note_ready", int'(note_ready), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_full", int'(full), 0);
    check("rst_block_count", int'(block_count), 0);
    rst = 1'b0;
    @(negedge clk);

    // Run A: one full block, then finish with empty slot -> terminator at 9.
    do_start(2'd0);
    check("a_busy", int'(busy), 1);
    check("a_ready", int'(note_ready), 1);
    full_block0(16'h1001);
    wait_ready();
    check("a_block_count", int'(block_count), 1);
    expect_wr(9, 16'hBF00);
    close_pulse(1'b0, 1'b1);
    wait_not_busy();
    check("a_done", int'(done), 1);
    check("a_busy_end", int'(busy), 0);
    check("a_block_count_end", int'(block_count), 1);

    // Run B: restart from DONE, full block, 3 notes + flush, empty flush, finish.
    do_start(2'd0);
    check("b_done_cleared", int'(done), 0);
    check("b_count_cleared", int'(block_count), 0);
    full_block0(16'h1001);
    send_note(16'h2001, 10, 1'b0, 1'b0);
    send_note(16'h2002, 11, 1'b0, 1'b0);
    send_note(16'h2003, 12, 1'b1, 1'b0);
    for (int a = 13; a <= 17; a++) expect_wr(a, 16'h0000);
    expect_wr(9, 16'hB013);
    wait_ready();
    check("b_block_count", int'(block_count), 2);
    close_pulse(1'b1, 1'b0);  // flush with slot 0: no effect
    repeat (3) @(negedge clk);
    check("b_empty_flush_ready", int'(note_ready), 1);
    check("b_empty_flush_count", int'(block_count), 2);
    expect_wr(18, 16'hBF00);
    close_pulse(1'b0, 1'b1);
    wait_not_busy();
    check("b_done", int'(done), 1);

    // Run C: region 2, one note then finish -> pad, header, terminator.
    do_start(2'd2);
    send_note(16'h3001, 257, 1'b0, 1'b0);
    for (int a = 258; a <= 264; a++) expect_wr(a, 16'h0000);
    expect_wr(256, 16'hB001);
    expect_wr(265, 16'hBF00);
    close_pulse(1'b0, 1'b1);
    wait_not_busy();
    check("c_done", int'(done), 1);
    check("c_block_count", int'(block_count), 1);
    check("c_full", int'(full), 0);

    // Run D: region 1, 112 notes fill all 14 blocks; no terminator.
    do_start(2'd1);
    for (int b = 0; b < 14; b++) begin
      for (int s = 0; s < 8; s++) send_note(16'h4000 + b * 8 + s, 128 + b * 9 + 1 + s, 1'b0, 1'b0);
      expect_wr(128 + b * 9, 16'hB008 | (b << 4));
    end
    wait_not_busy();
    check("d_full", int'(full), 1);
    check("d_block_count", int'(block_count), 14);
    check("d_ready", int'(note_ready), 0);
    check("d_done", int'(done), 1);
    note_in = 16'hFFFF; note_valid = 1'b1; flush = 1'b1; finish = 1'b1;
    repeat (4) @(negedge clk);
    note_valid = 1'b0; flush = 1'b0; finish = 1'b0;
    @(negedge clk);
    check("d_113th_count", int'(block_count), 14);
    check("d_113th_full", int'(full), 1);

    // Run E: reset while padding abandons the block.
    do_start(2'd0);
    check("e_full_cleared", int'(full), 0);
    full_block0(16'h5001);
    send_note(16'h5101, 10, 1'b0, 1'b0);
    send_note(16'h5102, 11, 1'b0, 1'b0);
    send_note(16'h5103, 12, 1'b1, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("e_wr_en", int'(wr_en), 0);
    check("e_ready", int'(note_ready), 0);
    check("e_busy", int'(busy), 0);
    check("e_done", int'(done), 0);
    check("e_block_count", int'(block_count), 0);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("e_ready_idle", int'(note_ready), 0);
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
